// File: rtl/data_types.sv
// Shared types for the memory port arbiter.
// Holds the arbiter state, source select and memory request bundle.
package data_types;

    typedef logic [31:0] word32_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        LS,
        IF
    } arb_src_t;

    typedef struct packed {
        logic    read;
        logic    write;
        word32_t addr;
        word32_t data;
    } mem_req_t;

    // A write strobe wins over a simultaneous read strobe.
    function automatic mem_req_t make_req(
        input logic    rd,
        input logic    wr,
        input word32_t addr,
        input word32_t data
    );
        mem_req_t r;
        r.read  = rd & ~wr;
        r.write = wr;
        r.addr  = addr;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Per-transaction cycle counter for the arbiter abort path.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // Fires during the last allowed ISSUE cycle.
    assign expired = enable && (count == CW'(CYCLES - 1));

    // Restart on transaction entry, count while the transaction is open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (load-store, fetch) arbiter onto one memory port.
// Optional abort timer enabled by defining MEM_ARB_TIMEOUT_EN.
import data_types::*;

module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    input  logic    ls_read_i,
    input  logic    ls_write_i,
    input  word32_t ls_addr_i,
    input  word32_t ls_data_i,
    output word32_t ls_rd_data_o,
    output logic    ls_done_o,
    input  logic    if_read_i,
    input  logic    if_write_i,
    input  word32_t if_addr_i,
    input  word32_t if_data_i,
    output word32_t if_rd_data_o,
    output logic    if_done_o,
    output logic    mem_read_o,
    output logic    mem_write_o,
    output word32_t mem_addr_o,
    output word32_t mem_data_o,
    input  word32_t mem_rd_data_i,
    input  logic    mem_done_i,
    output logic    err_timeout_o
);

    arb_state_t state;
    arb_src_t   src;
    arb_src_t   last_grant;
    mem_req_t   req_q;
    mem_req_t   next_req;
    logic       ls_req;
    logic       if_req;
    logic       any_req;
    logic       grant_if;
    logic       expired;
    logic       finish;

    assign ls_req   = ls_read_i | ls_write_i;
    assign if_req   = if_read_i | if_write_i;
    assign any_req  = ls_req | if_req;
    assign grant_if = if_req & (~ls_req | (last_grant == LS));
    assign finish   = mem_done_i | expired;

    // Pick the request bundle of whichever side wins this cycle.
    always_comb begin
        next_req = make_req(ls_read_i, ls_write_i, ls_addr_i, ls_data_i);
        if (grant_if) begin
            next_req = make_req(if_read_i, if_write_i, if_addr_i, if_data_i);
        end
    end

    assign mem_read_o  = req_q.read;
    assign mem_write_o = req_q.write;
    assign mem_addr_o  = req_q.addr;
    assign mem_data_o  = req_q.data;

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk_i),
        .reset   (reset_ni),
        .clear   ((state == IDLE) && any_req),
        .enable  (state == ISSUE),
        .expired (expired)
    );

    // Sticky abort flag; a completion in the same cycle is not an abort.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else if ((state == ISSUE) && expired && !mem_done_i) begin
            err_q <= 1'b1;
        end
    end

    assign err_timeout_o = err_q;
`else
    assign expired = 1'b0;
    // Parameter only matters for the timer; this folds to constant 0.
    assign err_timeout_o = (TIMEOUT_CYCLES < 0);
`endif

    // Arbitration FSM with registered memory strobes and responses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            src          <= LS;
            last_grant   <= IF;
            req_q        <= '0;
            ls_rd_data_o <= '0;
            if_rd_data_o <= '0;
            ls_done_o    <= 1'b0;
            if_done_o    <= 1'b0;
        end else begin
            ls_done_o <= 1'b0;
            if_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ISSUE;
                        src        <= grant_if ? IF : LS;
                        last_grant <= grant_if ? IF : LS;
                        req_q      <= next_req;
                    end
                end
                ISSUE: begin
                    if (finish) begin
                        state       <= RESP;
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                        if (src == IF) begin
                            if_done_o <= 1'b1;
                            if (mem_done_i && req_q.read) begin
                                if_rd_data_o <= mem_rd_data_i;
                            end
                        end else begin
                            ls_done_o <= 1'b1;
                            if (mem_done_i && req_q.read) begin
                                ls_rd_data_o <= mem_rd_data_i;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus corner sequences.
// Timer checks run when MEM_ARB_TIMEOUT_EN is defined.
import data_types::*;

module tb_mem_port_arbiter;

    logic    clk;
    logic    reset_ni;
    logic    ls_read_i;
    logic    ls_write_i;
    word32_t ls_addr_i;
    word32_t ls_data_i;
    word32_t ls_rd_data_o;
    logic    ls_done_o;
    logic    if_read_i;
    logic    if_write_i;
    word32_t if_addr_i;
    word32_t if_data_i;
    word32_t if_rd_data_o;
    logic    if_done_o;
    logic    mem_read_o;
    logic    mem_write_o;
    word32_t mem_addr_o;
    word32_t mem_data_o;
    word32_t mem_rd_data_i;
    logic    mem_done_i;
    logic    err_timeout_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .ls_read_i     (ls_read_i),
        .ls_write_i    (ls_write_i),
        .ls_addr_i     (ls_addr_i),
        .ls_data_i     (ls_data_i),
        .ls_rd_data_o  (ls_rd_data_o),
        .ls_done_o     (ls_done_o),
        .if_read_i     (if_read_i),
        .if_write_i    (if_write_i),
        .if_addr_i     (if_addr_i),
        .if_data_i     (if_data_i),
        .if_rd_data_o  (if_rd_data_o),
        .if_done_o     (if_done_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_rd_data_i (mem_rd_data_i),
        .mem_done_i    (mem_done_i),
        .err_timeout_o (err_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        bit          is_if;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          lat;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_ls_rd;
        logic [31:0] exp_if_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit is_if, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (is_if) begin
            if_read_i  = rd;
            if_write_i = wr;
            if_addr_i  = a;
            if_data_i  = d;
        end else begin
            ls_read_i  = rd;
            ls_write_i = wr;
            ls_addr_i  = a;
            ls_data_i  = d;
        end
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        drive(v.is_if, v.rd, v.wr, v.addr, v.data);
        tick();
        chk({t, " mem_read"}, 32'(mem_read_o), 32'(v.exp_rd));
        chk({t, " mem_write"}, 32'(mem_write_o), 32'(v.exp_wr));
        chk({t, " mem_addr"}, mem_addr_o, v.addr);
        chk({t, " mem_data"}, mem_data_o, v.data);
        repeat (v.lat - 1) tick();
        chk({t, " held"}, 32'(mem_read_o | mem_write_o), 32'd1);
        mem_done_i    = 1'b1;
        mem_rd_data_i = v.rdata;
        tick();
        mem_done_i = 1'b0;
        chk({t, " done"}, 32'(v.is_if ? if_done_o : ls_done_o), 32'd1);
        chk({t, " other_done"}, 32'(v.is_if ? ls_done_o : if_done_o), 32'd0);
        chk({t, " strobe_drop"}, 32'(mem_read_o | mem_write_o), 32'd0);
        chk({t, " ls_rd_data"}, ls_rd_data_o, v.exp_ls_rd);
        chk({t, " if_rd_data"}, if_rd_data_o, v.exp_if_rd);
        tick();
        drive(v.is_if, 1'b0, 1'b0, 32'h0, 32'h0);
        chk({t, " done_pulse"}, 32'(ls_done_o | if_done_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 4, 1, 0,
                    32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 0, 1, 32'h40, 32'h1234, 32'hAAAA5555, 1, 0, 1,
                    32'hDEADBEEF, 32'h0};
        vecs[2] = '{1, 1, 0, 32'h200, 32'h7, 32'hCAFEF00D, 2, 1, 0,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{0, 1, 1, 32'h300, 32'h55, 32'h99999999, 1, 0, 1,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{0, 0, 1, 32'h104, 32'hFFFFFFFF, 32'h1, 3, 0, 1,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[5] = '{1, 1, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0,
                    32'hDEADBEEF, 32'h0};

        reset_ni      = 1'b1;
        ls_read_i     = 1'b0;
        ls_write_i    = 1'b0;
        ls_addr_i     = '0;
        ls_data_i     = '0;
        if_read_i     = 1'b0;
        if_write_i    = 1'b0;
        if_addr_i     = '0;
        if_data_i     = '0;
        mem_rd_data_i = '0;
        mem_done_i    = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst mem_read", 32'(mem_read_o), 32'd0);
        chk("rst mem_write", 32'(mem_write_o), 32'd0);
        chk("rst mem_addr", mem_addr_o, 32'h0);
        chk("rst ls_done", 32'(ls_done_o), 32'd0);
        chk("rst if_done", 32'(if_done_o), 32'd0);
        chk("rst ls_rd", ls_rd_data_o, 32'h0);
        chk("rst err", 32'(err_timeout_o), 32'd0);
        tick();
        reset_ni = 1'b1;
        tick();

        // stray completion while idle
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h12345678;
        tick();
        mem_done_i = 1'b0;
        tick();
        chk("idle_done ls", 32'(ls_done_o), 32'd0);
        chk("idle_done if", 32'(if_done_o), 32'd0);
        chk("idle_done strobe", 32'(mem_read_o | mem_write_o), 32'd0);
        chk("idle_done rd", ls_rd_data_o, 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // simultaneous requests after reset: LS first, IF three cycles on
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("tie first addr", mem_addr_o, 32'h10);
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h11111111;
        tick();
        mem_done_i = 1'b0;
        chk("tie ls_done", 32'(ls_done_o), 32'd1);
        chk("tie if_done0", 32'(if_done_o), 32'd0);
        chk("tie ls_rd", ls_rd_data_o, 32'h11111111);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tie idle read", 32'(mem_read_o), 32'd0);
        tick();
        chk("tie second read", 32'(mem_read_o), 32'd1);
        chk("tie second addr", mem_addr_o, 32'h20);
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h22222222;
        tick();
        mem_done_i = 1'b0;
        chk("tie if_done", 32'(if_done_o), 32'd1);
        chk("tie ls_done0", 32'(ls_done_o), 32'd0);
        chk("tie if_rd", if_rd_data_o, 32'h22222222);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset during ISSUE, then a stray completion
        drive(0, 1'b1, 1'b0, 32'h80, 32'h0);
        tick();
        chk("mid_rst issue", 32'(mem_read_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("mid_rst read", 32'(mem_read_o), 32'd0);
        chk("mid_rst addr", mem_addr_o, 32'h0);
        chk("mid_rst ls_rd", ls_rd_data_o, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset_ni      = 1'b1;
        mem_done_i    = 1'b1;
        mem_rd_data_i = 32'h33333333;
        tick();
        mem_done_i = 1'b0;
        chk("mid_rst no_done", 32'(ls_done_o | if_done_o), 32'd0);
        tick();
        chk("mid_rst no_done2", 32'(ls_done_o | if_done_o), 32'd0);
        chk("mid_rst idle", 32'(mem_read_o | mem_write_o), 32'd0);
        chk("mid_rst rd", ls_rd_data_o, 32'h0);

        // memory never answers
        drive(0, 1'b1, 1'b0, 32'h500, 32'h0);
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (7) tick();
        chk("to last_issue", 32'(mem_read_o), 32'd1);
        chk("to no_done_yet", 32'(ls_done_o), 32'd0);
        chk("to err_early", 32'(err_timeout_o), 32'd0);
        tick();
        chk("to done", 32'(ls_done_o), 32'd1);
        chk("to strobe", 32'(mem_read_o), 32'd0);
        chk("to err", 32'(err_timeout_o), 32'd1);
        chk("to rd_keep", ls_rd_data_o, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        chk("to err_sticky", 32'(err_timeout_o), 32'd1);
`else
        repeat (40) tick();
        chk("hang strobe", 32'(mem_read_o), 32'd1);
        chk("hang addr", mem_addr_o, 32'h500);
        chk("hang done", 32'(ls_done_o), 32'd0);
        chk("hang err", 32'(err_timeout_o), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
        do_reset();
        chk("final err", 32'(err_timeout_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
